dma_icb_arbiter: RTL

- 2:1 ICB arbiter that shares the single system-memory ICB slave port between the E203 core data master (m0) and the dma_core master (m1).
- Arbitrates commands and enforces grant stability under slave back-pressure.
- Records the issuing master of every accepted command and routes the in-order responses back to that master.
- Sits between dma_core / core LSU and the SRAM/bus fabric.

---
 rtl/dma_icb_arbiter_pkg.sv | 13 +
 rtl/dma_arb_id_fifo.sv | 64 ++++++
 rtl/dma_icb_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/dma_icb_arbiter_pkg.sv
// Shared constants for the DMA/core ICB arbiter: master IDs, default depth and
// arbitration-mode encodings.
package dma_icb_arbiter_pkg;

   localparam logic MID_CORE = 1'b0;
   localparam logic MID_DMA  = 1'b1;

   localparam int unsigned OUTS_DEPTH_DEF = 4;

   localparam int unsigned ARB_RR        = 0;
   localparam int unsigned ARB_CORE_PRIO = 1;

endpackage

// File: rtl/dma_arb_id_fifo.sv
// DEPTH x 1-bit synchronous FIFO holding the issuing master ID of every
// outstanding command; DEPTH must be a power of two so the pointers wrap freely.
module dma_arb_id_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  logic                   din_i,
   input  logic                   pop_i,
   output logic                   dout_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
   localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

   logic [DEPTH-1:0] mem_q;
   logic [PW-1:0]    wptr_q;
   logic [PW-1:0]    rptr_q;
   logic [PW:0]      cnt_q;
   logic [PW:0]      cnt_d;
   logic             push_en;
   logic             pop_en;

   assign full_o  = (cnt_q == CNT_FULL);
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign dout_o  = mem_q[rptr_q];

   assign push_en = push_i & ~full_o;
   assign pop_en  = pop_i & ~empty_o;

   always_comb begin
      cnt_d = cnt_q;
      unique case ({push_en, pop_en})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q  <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (push_en) begin
            mem_q[wptr_q] <= din_i;
            wptr_q        <= wptr_q + PW'(1);
         end
         if (pop_en) begin
            rptr_q <= rptr_q + PW'(1);
         end
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/dma_icb_arbiter.sv
// 2:1 ICB arbiter sharing the system-memory slave between the core LSU (m0) and
// dma_core (m1); responses return in order to the master that issued them.
module dma_icb_arbiter
   import dma_icb_arbiter_pkg::*;
#(
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 32,
   parameter int unsigned OUTS_DEPTH = OUTS_DEPTH_DEF,
   parameter int unsigned CORE_PRIO  = ARB_RR
) (
   input  logic                         clk,
   input  logic                         rst_n,

   input  logic                         m0_cmd_valid,
   output logic                         m0_cmd_ready,
   input  logic [AW-1:0]                m0_cmd_addr,
   input  logic                         m0_cmd_read,
   input  logic [DW-1:0]                m0_cmd_wdata,
   input  logic [DW/8-1:0]              m0_cmd_wmask,
   output logic                         m0_rsp_valid,
   input  logic                         m0_rsp_ready,
   output logic                         m0_rsp_err,
   output logic [DW-1:0]                m0_rsp_rdata,

   input  logic                         m1_cmd_valid,
   output logic                         m1_cmd_ready,
   input  logic [AW-1:0]                m1_cmd_addr,
   input  logic                         m1_cmd_read,
   input  logic [DW-1:0]                m1_cmd_wdata,
   input  logic [DW/8-1:0]              m1_cmd_wmask,
   output logic                         m1_rsp_valid,
   input  logic                         m1_rsp_ready,
   output logic                         m1_rsp_err,
   output logic [DW-1:0]                m1_rsp_rdata,

   output logic                         s_cmd_valid,
   input  logic                         s_cmd_ready,
   output logic [AW-1:0]                s_cmd_addr,
   output logic                         s_cmd_read,
   output logic [DW-1:0]                s_cmd_wdata,
   output logic [DW/8-1:0]              s_cmd_wmask,
   input  logic                         s_rsp_valid,
   output logic                         s_rsp_ready,
   input  logic                         s_rsp_err,
   input  logic [DW-1:0]                s_rsp_rdata,

   output logic [$clog2(OUTS_DEPTH):0]  outs_cnt
);

   logic grant;
   logic grant_valid;
   logic lock_q;
   logic locked_id_q;
   logic rr_ptr_q;
   logic cmd_hs;
   logic cmd_ok;
   logic rsp_hs;
   logic rsp_act;
   logic fifo_full;
   logic fifo_empty;
   logic head_id;

   // A stalled command keeps its grant so the slave sees stable fields.
   always_comb begin
      grant = MID_CORE;
      if (lock_q) begin
         grant = locked_id_q;
      end else if (CORE_PRIO == ARB_CORE_PRIO) begin
         grant = m0_cmd_valid ? MID_CORE : MID_DMA;
      end else if (m0_cmd_valid && m1_cmd_valid) begin
         grant = rr_ptr_q;
      end else if (m1_cmd_valid) begin
         grant = MID_DMA;
      end
   end

   assign grant_valid = (grant == MID_DMA) ? m1_cmd_valid : m0_cmd_valid;

   assign s_cmd_valid = grant_valid & ~fifo_full;
   assign s_cmd_addr  = (grant == MID_DMA) ? m1_cmd_addr  : m0_cmd_addr;
   assign s_cmd_read  = (grant == MID_DMA) ? m1_cmd_read  : m0_cmd_read;
   assign s_cmd_wdata = (grant == MID_DMA) ? m1_cmd_wdata : m0_cmd_wdata;
   assign s_cmd_wmask = (grant == MID_DMA) ? m1_cmd_wmask : m0_cmd_wmask;

   assign cmd_ok       = grant_valid & s_cmd_ready & ~fifo_full;
   assign m0_cmd_ready = cmd_ok & (grant == MID_CORE);
   assign m1_cmd_ready = cmd_ok & (grant == MID_DMA);
   assign cmd_hs       = s_cmd_valid & s_cmd_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_q      <= 1'b0;
         locked_id_q <= MID_CORE;
         rr_ptr_q    <= MID_CORE;
      end else begin
         lock_q      <= s_cmd_valid & ~s_cmd_ready;
         locked_id_q <= grant;
         if (cmd_hs) begin
            rr_ptr_q <= ~grant;
         end
      end
   end

   // With no recorded command there is no owner, so stray responses are never accepted.
   assign rsp_act      = ~fifo_empty;
   assign m0_rsp_valid = rsp_act & s_rsp_valid & (head_id == MID_CORE);
   assign m1_rsp_valid = rsp_act & s_rsp_valid & (head_id == MID_DMA);
   assign s_rsp_ready  = rsp_act & ((head_id == MID_DMA) ? m1_rsp_ready : m0_rsp_ready);
   assign rsp_hs       = s_rsp_valid & s_rsp_ready;

   assign m0_rsp_err   = s_rsp_err;
   assign m1_rsp_err   = s_rsp_err;
   assign m0_rsp_rdata = s_rsp_rdata;
   assign m1_rsp_rdata = s_rsp_rdata;

   dma_arb_id_fifo #(
      .DEPTH (OUTS_DEPTH)
   ) u_id_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (cmd_hs),
      .din_i   (grant),
      .pop_i   (rsp_hs),
      .dout_o  (head_id),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (outs_cnt)
   );

endmodule
